// File: rtl/ieee_adder_pipe_pkg.sv
// Shared helpers for the pipelined IEEE-754 adder: word width, field slices,
// canonical special-value encodings and the round-to-nearest-even threshold.
package ieee_adder_pipe_pkg;

  localparam int unsigned MAX_W = 128;

  function automatic int unsigned word_w(input int unsigned exp_w, input int unsigned man_w);
    return 1 + exp_w + man_w;
  endfunction

  function automatic logic [MAX_W-1:0] field_exp(input logic [MAX_W-1:0] w,
                                                 input int unsigned exp_w,
                                                 input int unsigned man_w);
    return (w >> man_w) & ((MAX_W'(1) << exp_w) - MAX_W'(1));
  endfunction

  function automatic logic [MAX_W-1:0] field_frac(input logic [MAX_W-1:0] w,
                                                  input int unsigned man_w);
    return w & ((MAX_W'(1) << man_w) - MAX_W'(1));
  endfunction

  // Positive infinity: exponent all ones, fraction zero.
  function automatic logic [MAX_W-1:0] inf_word(input int unsigned exp_w, input int unsigned man_w);
    logic [MAX_W-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i >= man_w && i < man_w + exp_w) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Canonical quiet NaN: +, exponent all ones, fraction MSB set.
  function automatic logic [MAX_W-1:0] qnan_word(input int unsigned exp_w, input int unsigned man_w);
    return inf_word(exp_w, man_w) | (MAX_W'(1) << (man_w - 1));
  endfunction

  // Guard-field value of exactly one half ULP.
  function automatic logic [MAX_W-1:0] round_even(input int unsigned guard_w);
    return MAX_W'(1) << (guard_w - 1);
  endfunction

endpackage

// File: rtl/ieee_lzc.sv
// Parametrised leading-zero counter; returns WIDTH for an all-zero input.
module ieee_lzc #(
  parameter int unsigned WIDTH = 27,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] din,
  output logic [CNT_W-1:0] cnt
);

  // Highest set bit wins because it is visited last.
  always_comb begin
    cnt = CNT_W'(WIDTH);
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (din[i]) cnt = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/ieee_adder_pipe.sv
// 3-stage IEEE-754 adder/subtractor with valid/ready handshake and sideband tag.
// Define IEEE_ADDER_FLAGS_EN to add the out_flags exception port.
module ieee_adder_pipe
  import ieee_adder_pipe_pkg::*;
#(
  parameter int unsigned EXP_W   = 8,
  parameter int unsigned MAN_W   = 23,
  parameter int unsigned GUARD_W = 3,
  parameter int unsigned TAG_W   = 4,
  localparam int unsigned W      = word_w(EXP_W, MAN_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sub,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_c,
  output logic [TAG_W-1:0] out_tag
`ifdef IEEE_ADDER_FLAGS_EN
  ,
  output logic [3:0]       out_flags
`endif
);

  localparam int unsigned AW     = MAN_W + 1 + GUARD_W;
  localparam int unsigned SH_MAX = MAN_W + GUARD_W + 2;
  localparam int unsigned LZ_W   = $clog2(AW + 1);
  localparam int unsigned SW     = (LZ_W > EXP_W + 1) ? LZ_W : EXP_W + 1;
  localparam logic [W-1:0]       QNAN    = W'(qnan_word(EXP_W, MAN_W));
  localparam logic [W-1:0]       INF_P   = W'(inf_word(EXP_W, MAN_W));
  localparam logic [GUARD_W-1:0] HALF    = GUARD_W'(round_even(GUARD_W));
  localparam logic [EXP_W:0]     EXP_MAX = {1'b0, {EXP_W{1'b1}}};

  logic s1_valid, s2_valid;
  logic out_en, s2_en, s1_en;

  // Each stage loads when its successor is empty or draining this cycle.
  always_comb begin
    out_en = !out_valid || out_ready;
    s2_en  = !s2_valid || out_en;
    s1_en  = !s1_valid || s2_en;
  end
  assign in_ready = s1_en;

  // S1: unpack, specials, order by magnitude, align the smaller operand.
  logic             sa, sb, sl, ss, swap, nan_a, nan_b, inf_a, inf_b, byp;
  logic [EXP_W-1:0] ea, eb, el, es, el_eff, es_eff, d;
  logic [MAN_W-1:0] fa, fb, fl, fs;
  logic [AW-1:0]    big, small_al;
  logic [2*AW-1:0]  ext;
  logic [W-1:0]     byp_val;
`ifdef IEEE_ADDER_FLAGS_EN
  logic             byp_inv;
`endif

  always_comb begin
    sa     = in_a[W-1];
    sb     = in_b[W-1] ^ in_sub;
    ea     = EXP_W'(field_exp(MAX_W'(in_a), EXP_W, MAN_W));
    eb     = EXP_W'(field_exp(MAX_W'(in_b), EXP_W, MAN_W));
    fa     = MAN_W'(field_frac(MAX_W'(in_a), MAN_W));
    fb     = MAN_W'(field_frac(MAX_W'(in_b), MAN_W));
    nan_a  = (&ea) && (|fa);
    nan_b  = (&eb) && (|fb);
    inf_a  = (&ea) && !(|fa);
    inf_b  = (&eb) && !(|fb);
    swap   = in_b[W-2:0] > in_a[W-2:0];
    sl     = swap ? sb : sa;
    ss     = swap ? sa : sb;
    el     = swap ? eb : ea;
    es     = swap ? ea : eb;
    fl     = swap ? fb : fa;
    fs     = swap ? fa : fb;
    el_eff = (el == '0) ? EXP_W'(1) : el;
    es_eff = (es == '0) ? EXP_W'(1) : es;
    d      = el_eff - es_eff;
    big    = {|el, fl, GUARD_W'(0)};
    ext    = {|es, fs, GUARD_W'(0), AW'(0)} >> d;
    if (32'(d) >= 32'(SH_MAX)) small_al = {(AW-1)'(0), |{es, fs}};
    else                       small_al = {ext[2*AW-1:AW+1], ext[AW] | (|ext[AW-1:0])};

    byp     = nan_a || nan_b || inf_a || inf_b;
    byp_val = QNAN;
    if (nan_a || nan_b)     byp_val = QNAN;
    else if (inf_a && inf_b) byp_val = (sa == sb) ? {sa, INF_P[W-2:0]} : QNAN;
    else if (inf_a)         byp_val = {sa, INF_P[W-2:0]};
    else if (inf_b)         byp_val = {sb, INF_P[W-2:0]};
`ifdef IEEE_ADDER_FLAGS_EN
    byp_inv = (nan_a && !fa[MAN_W-1]) || (nan_b && !fb[MAN_W-1]) ||
              (inf_a && inf_b && (sa != sb));
`endif
  end

  logic [TAG_W-1:0] s1_tag;
  logic             s1_sign, s1_sub, s1_byp;
  logic [EXP_W-1:0] s1_exp;
  logic [AW-1:0]    s1_big, s1_small;
  logic [W-1:0]     s1_bval;
`ifdef IEEE_ADDER_FLAGS_EN
  logic             s1_inv;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_tag   <= '0;
      s1_sign  <= 1'b0;
      s1_sub   <= 1'b0;
      s1_byp   <= 1'b0;
      s1_exp   <= '0;
      s1_big   <= '0;
      s1_small <= '0;
      s1_bval  <= '0;
`ifdef IEEE_ADDER_FLAGS_EN
      s1_inv   <= 1'b0;
`endif
    end else if (s1_en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_tag   <= in_tag;
        s1_sign  <= sl;
        s1_sub   <= sl ^ ss;
        s1_byp   <= byp;
        s1_exp   <= el_eff;
        s1_big   <= big;
        s1_small <= small_al;
        s1_bval  <= byp_val;
`ifdef IEEE_ADDER_FLAGS_EN
        s1_inv   <= byp_inv;
`endif
      end
    end
  end

  // S2: add/subtract, then carry shift or clamped left normalisation.
  logic [AW:0]     sum;
  logic [LZ_W-1:0] lz;
  logic [SW-1:0]   sh, lim;
  logic [AW-1:0]   m2;
  logic [EXP_W:0]  e2;

  ieee_lzc #(.WIDTH(AW)) u_lzc (
    .din (sum[AW-1:0]),
    .cnt (lz)
  );

  always_comb begin
    sum = s1_sub ? ({1'b0, s1_big} - {1'b0, s1_small}) : ({1'b0, s1_big} + {1'b0, s1_small});
    e2  = {1'b0, s1_exp};
    m2  = sum[AW-1:0];
    lim = SW'(s1_exp) - SW'(1);
    sh  = (SW'(lz) < lim) ? SW'(lz) : lim;
    if (!s1_sub && sum[AW]) begin
      m2 = {sum[AW:2], sum[1] | sum[0]};
      e2 = e2 + (EXP_W+1)'(1);
    end else if (s1_sub) begin
      m2 = sum[AW-1:0] << sh;
      e2 = e2 - (EXP_W+1)'(sh);
    end
  end

  logic [TAG_W-1:0] s2_tag;
  logic             s2_sign, s2_zsign, s2_byp;
  logic [EXP_W:0]   s2_exp;
  logic [AW-1:0]    s2_m;
  logic [W-1:0]     s2_bval;
`ifdef IEEE_ADDER_FLAGS_EN
  logic             s2_inv;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_tag   <= '0;
      s2_sign  <= 1'b0;
      s2_zsign <= 1'b0;
      s2_byp   <= 1'b0;
      s2_exp   <= '0;
      s2_m     <= '0;
      s2_bval  <= '0;
`ifdef IEEE_ADDER_FLAGS_EN
      s2_inv   <= 1'b0;
`endif
    end else if (s2_en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_tag   <= s1_tag;
        s2_sign  <= s1_sign;
        s2_zsign <= s1_sub ? 1'b0 : s1_sign;
        s2_byp   <= s1_byp;
        s2_exp   <= e2;
        s2_m     <= m2;
        s2_bval  <= s1_bval;
`ifdef IEEE_ADDER_FLAGS_EN
        s2_inv   <= s1_inv;
`endif
      end
    end
  end

  // S3: round to nearest even, renormalise on carry-out, pack.
  logic [GUARD_W-1:0] g;
  logic               rup;
  logic [MAN_W+1:0]   rnd;
  logic [MAN_W:0]     sig3;
  logic [EXP_W:0]     e3;
  logic [W-1:0]       res;
`ifdef IEEE_ADDER_FLAGS_EN
  logic [3:0]         flags;
`endif

  always_comb begin
    g    = s2_m[GUARD_W-1:0];
    rup  = (g > HALF) || ((g == HALF) && s2_m[GUARD_W]);
    rnd  = {1'b0, s2_m[AW-1:GUARD_W]} + (MAN_W+2)'(rup);
    sig3 = rnd[MAN_W:0];
    e3   = s2_exp;
    if (rnd[MAN_W+1]) begin
      sig3 = rnd[MAN_W+1:1];
      e3   = s2_exp + (EXP_W+1)'(1);
    end
    if (s2_byp)             res = s2_bval;
    else if (e3 >= EXP_MAX) res = {s2_sign, INF_P[W-2:0]};
    else if (s2_m == '0)    res = {s2_zsign, (W-1)'(0)};
    else                    res = {s2_sign, sig3[MAN_W] ? e3[EXP_W-1:0] : EXP_W'(0), sig3[MAN_W-1:0]};
`ifdef IEEE_ADDER_FLAGS_EN
    flags = 4'b0000;
    if (s2_byp) begin
      flags[3] = s2_inv;
    end else begin
      flags[2] = e3 >= EXP_MAX;
      flags[1] = !s2_m[AW-1] && (|g);
      flags[0] = |g;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_c     <= '0;
      out_tag   <= '0;
`ifdef IEEE_ADDER_FLAGS_EN
      out_flags <= '0;
`endif
    end else if (out_en) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_c     <= res;
        out_tag   <= s2_tag;
`ifdef IEEE_ADDER_FLAGS_EN
        out_flags <= flags;
`endif
      end
    end
  end

endmodule
